vram_arbiter: RTL and testbench

//  Shares the single text VRAM port (addr {5'y,6'x}, 8-bit data) between two requesters:

---
 rtl/vram_arbiter.sv | 145 ++++++++++++++
 tb/tb_vram_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: two requesters share the text VRAM port; round-robin owner, lock, burst limit, tagged reads.
// Latency: grant 1 cycle after request seen idle; vram ce 1 cycle after accept; read data RD_LAT+1 after accept.
// Backpressure: a port stalls while its grant is low; every ownership change passes through one idle cycle.
module vram_arbiter #(
    parameter int AW        = 11,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_lock0,
    input  logic          i_lock1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic          i_w0,
    input  logic          i_w1,
    input  logic [DW-1:0] i_din0,
    input  logic [DW-1:0] i_din1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_rvalid0,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rdata,
    output logic [AW-1:0] o_vram_addr,
    output logic [DW-1:0] o_vram_din,
    output logic          o_vram_ce,
    output logic          o_vram_w,
    input  logic [DW-1:0] i_vram_dout
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_OWN0 = 2'b01;
    localparam logic [1:0] S_OWN1 = 2'b10;

    localparam int             BCW       = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BCW-1:0] BURST_SAT = MAX_BURST[BCW-1:0];

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last_served;
    logic [BCW-1:0]    burst_cnt;
    logic              acc0;
    logic              acc1;
    logic              accept;
    logic              burst_hit;
    logic              rel0;
    logic              rel1;
    logic              vram_port;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_port;

    // One-hot owner states make the grants plain register bits.
    assign o_gnt0 = state[0];
    assign o_gnt1 = state[1];

    assign acc0   = i_req0 & o_gnt0;
    assign acc1   = i_req1 & o_gnt1;
    assign accept = acc0 | acc1;

    // Counting the access accepted this edge lets the limit stop the owner after exactly MAX_BURST accesses.
    assign burst_hit = (MAX_BURST != 0) &&
                       (({1'b0, burst_cnt} + {{BCW{1'b0}}, accept}) >= {1'b0, BURST_SAT});

    assign rel0 = !i_lock0 && (!i_req0 || (burst_hit && i_req1));
    assign rel1 = !i_lock1 && (!i_req1 || (burst_hit && i_req0));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_req0 && (!i_req1 || last_served)) begin
                    state_nxt = S_OWN0;
                end else if (i_req1) begin
                    state_nxt = S_OWN1;
                end
            end
            S_OWN0:  if (rel0) state_nxt = S_IDLE;
            S_OWN1:  if (rel1) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            last_served <= 1'b1;
            burst_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state != S_IDLE && state_nxt == S_IDLE) begin
                last_served <= state[1];
            end
            if (state_nxt != state) begin
                burst_cnt <= '0;
            end else if (accept && burst_cnt < BURST_SAT) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_vram_ce   <= 1'b0;
            o_vram_w    <= 1'b0;
            o_vram_addr <= '0;
            o_vram_din  <= '0;
            vram_port   <= 1'b0;
        end else begin
            o_vram_ce <= accept;
            if (accept) begin
                o_vram_addr <= acc1 ? i_addr1 : i_addr0;
                o_vram_din  <= acc1 ? i_din1  : i_din0;
                o_vram_w    <= acc1 ? i_w1    : i_w0;
                vram_port   <= acc1;
            end
        end
    end

    // Tags follow each read from its ce cycle so data reaches the issuing port after the grant moves on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_vld   <= '0;
            tag_port  <= '0;
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
            o_rdata   <= '0;
        end else begin
            tag_vld[0]  <= o_vram_ce & ~o_vram_w;
            tag_port[0] <= vram_port;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_port[i] <= tag_port[i-1];
            end
            o_rvalid0 <= tag_vld[RD_LAT-1] & ~tag_port[RD_LAT-1];
            o_rvalid1 <= tag_vld[RD_LAT-1] &  tag_port[RD_LAT-1];
            if (tag_vld[RD_LAT-1]) begin
                o_rdata <= i_vram_dout;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized two-port traffic against a queue/shadow-memory model.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req  [2];
    logic        lock [2];
    logic        w    [2];
    logic [10:0] addr [2];
    logic [7:0]  din  [2];

    logic        gnt0, gnt1, rvalid0, rvalid1, vram_ce, vram_w;
    logic [7:0]  rdata, vram_din, vram_dout;
    logic [10:0] vram_addr;

    logic [7:0]  vmem   [0:2047];
    logic [7:0]  shadow [0:2047];

    typedef struct {
        int         due;
        logic       port;
        logic [7:0] data;
    } rd_t;
    rd_t rq[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0      (req[0]),
        .i_req1      (req[1]),
        .i_lock0     (lock[0]),
        .i_lock1     (lock[1]),
        .i_addr0     (addr[0]),
        .i_addr1     (addr[1]),
        .i_w0        (w[0]),
        .i_w1        (w[1]),
        .i_din0      (din[0]),
        .i_din1      (din[1]),
        .o_gnt0      (gnt0),
        .o_gnt1      (gnt1),
        .o_rvalid0   (rvalid0),
        .o_rvalid1   (rvalid1),
        .o_rdata     (rdata),
        .o_vram_addr (vram_addr),
        .o_vram_din  (vram_din),
        .o_vram_ce   (vram_ce),
        .o_vram_w    (vram_w),
        .i_vram_dout (vram_dout)
    );

    function automatic logic [7:0] init_val(input logic [10:0] a);
        if (a == 11'h7C0) return 8'h5A;
        if (a == 11'h123) return 8'hC3;
        return a[7:0] ^ {a[10:8], 5'h15};
    endfunction

    // VRAM with one cycle read latency.
    initial begin : vram_model
        vram_dout = 8'h00;
        for (int a = 0; a < 2048; a++) vmem[a] = init_val(11'(a));
        forever begin
            @(posedge clk);
            if (vram_ce) begin
                if (vram_w) vmem[vram_addr] = vram_din;
                vram_dout <= vmem[vram_addr];
            end
        end
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_a(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp_v);
        n_chk++;
        assert (obs == exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        for (int p = 0; p < 2; p++) begin
            req[p]  = 1'b0;
            lock[p] = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : main
        int         i, ce_cnt, stall, n_acc0, n_acc1;
        bit         gseen, prev_v, ev0, ev1;
        bit         acc [2];
        bit         acc_prev [2];
        logic [10:0] prev_a;
        logic [7:0]  prev_d, ed;
        logic        prev_w;
        rd_t         e;

        for (int a = 0; a < 2048; a++) shadow[a] = init_val(11'(a));
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; lock[p] = 1'b0; w[p] = 1'b0; addr[p] = 11'h000; din[p] = 8'h00;
        end

        // Reset state
        #1;
        chk_b("rst_gnt0", gnt0, 1'b0);
        chk_b("rst_gnt1", gnt1, 1'b0);
        chk_b("rst_ce", vram_ce, 1'b0);
        chk_b("rst_w", vram_w, 1'b0);
        chk_a("rst_addr", vram_addr, 11'h000);
        chk_d("rst_din", vram_din, 8'h00);
        chk_b("rst_rv0", rvalid0, 1'b0);
        chk_b("rst_rv1", rvalid1, 1'b0);
        chk_d("rst_rdata", rdata, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write from port 0
        req[0] = 1'b1; w[0] = 1'b1; addr[0] = 11'h041; din[0] = 8'h41;
        step();
        chk_b("wr_gnt0", gnt0, 1'b1);
        chk_b("wr_ce_early", vram_ce, 1'b0);
        step();
        chk_b("wr_ce", vram_ce, 1'b1);
        chk_a("wr_addr", vram_addr, 11'h041);
        chk_d("wr_din", vram_din, 8'h41);
        chk_b("wr_w", vram_w, 1'b1);
        req[0] = 1'b0;
        step();
        chk_b("wr_ce_once", vram_ce, 1'b0);
        chk_b("wr_release", gnt0, 1'b0);

        // Read latency on port 1
        req[1] = 1'b1; w[1] = 1'b0; addr[1] = 11'h7C0;
        step();
        chk_b("rd_gnt1", gnt1, 1'b1);
        step();
        chk_b("rd_ce", vram_ce, 1'b1);
        chk_b("rd_w", vram_w, 1'b0);
        chk_a("rd_addr", vram_addr, 11'h7C0);
        req[1] = 1'b0;
        step();
        chk_b("rd_rv1_early", rvalid1, 1'b0);
        step();
        chk_b("rd_rv1", rvalid1, 1'b1);
        chk_d("rd_data", rdata, 8'h5A);
        chk_b("rd_rv0", rvalid0, 1'b0);
        step();
        chk_b("rd_rv1_pulse", rvalid1, 1'b0);

        // Contention from reset, then round robin
        do_reset();
        req[0] = 1'b1; w[0] = 1'b1; addr[0] = 11'h050; din[0] = 8'hA0;
        req[1] = 1'b1; w[1] = 1'b1; addr[1] = 11'h051; din[1] = 8'hB1;
        step();
        chk_b("ct_first0", gnt0, 1'b1);
        chk_b("ct_first1", gnt1, 1'b0);
        step();
        chk_a("ct_addr0", vram_addr, 11'h050);
        req[0] = 1'b0;
        step();
        chk_b("ct_dead0", gnt0, 1'b0);
        chk_b("ct_dead1", gnt1, 1'b0);
        req[0] = 1'b1; din[0] = 8'hA2;
        step();
        chk_b("ct_rr1", gnt1, 1'b1);
        chk_b("ct_rr0", gnt0, 1'b0);
        step();
        chk_a("ct_addr1", vram_addr, 11'h051);
        chk_d("ct_din1", vram_din, 8'hB1);
        req[1] = 1'b0;
        step();
        chk_b("ct_dead_b", gnt0, 1'b0);
        step();
        chk_b("ct_back0", gnt0, 1'b1);
        req[0] = 1'b0;
        step();
        step();

        // Burst limit, unlocked owner
        do_reset();
        req[1] = 1'b1; w[1] = 1'b1; addr[1] = 11'h060; din[1] = 8'h66;
        i = 0; ce_cnt = 0; gseen = 1'b0;
        for (int c = 0; c < 300 && !gseen; c++) begin
            req[0] = 1'b1; w[0] = 1'b1; addr[0] = 11'(i); din[0] = 8'(i);
            acc[0] = gnt0;
            step();
            if (acc[0]) i++;
            if (vram_ce) ce_cnt++;
            if (gnt1) gseen = 1'b1;
        end
        chk_n("bl_ce", ce_cnt, 64);
        chk_n("bl_acc", i, 64);
        chk_b("bl_gnt1", gseen, 1'b1);

        // Locked owner completes all 100
        do_reset();
        lock[0] = 1'b1; req[1] = 1'b1;
        i = 0; ce_cnt = 0; stall = 0; gseen = 1'b0;
        for (int c = 0; c < 300 && i < 100; c++) begin
            req[0] = 1'b1; w[0] = 1'b1; addr[0] = 11'(i); din[0] = 8'(i);
            acc[0] = gnt0;
            if (i > 0 && !gnt0) stall++;
            if (gnt1) gseen = 1'b1;
            step();
            if (acc[0]) i++;
            if (vram_ce) ce_cnt++;
        end
        chk_n("lk_acc", i, 100);
        chk_n("lk_ce", ce_cnt, 100);
        chk_n("lk_stall", stall, 0);
        chk_b("lk_no_gnt1", gseen, 1'b0);
        req[0] = 1'b0;
        step();
        chk_b("lk_hold", gnt0, 1'b1);
        chk_b("lk_hold_ce", vram_ce, 1'b0);
        step();
        chk_b("lk_hold2", gnt0, 1'b1);
        lock[0] = 1'b0;
        step();
        chk_b("lk_release", gnt0, 1'b0);
        step();
        chk_b("lk_handoff", gnt1, 1'b1);
        req[1] = 1'b0;
        step();
        step();

        // Grant switch with a read in flight
        do_reset();
        req[0] = 1'b1; w[0] = 1'b0; addr[0] = 11'h123;
        req[1] = 1'b1; w[1] = 1'b1; addr[1] = 11'h061; din[1] = 8'h77;
        step();
        chk_b("sw_gnt0", gnt0, 1'b1);
        step();
        chk_b("sw_ce", vram_ce, 1'b1);
        chk_b("sw_rd", vram_w, 1'b0);
        req[0] = 1'b0;
        step();
        chk_b("sw_idle", gnt0, 1'b0);
        chk_b("sw_rv0_early", rvalid0, 1'b0);
        step();
        chk_b("sw_gnt1", gnt1, 1'b1);
        chk_b("sw_rv0", rvalid0, 1'b1);
        chk_d("sw_data", rdata, 8'hC3);
        chk_b("sw_rv1", rvalid1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk_b("sw_no_rv1", rvalid1, 1'b0);
            chk_b("sw_rv0_pulse", rvalid0, 1'b0);
        end
        req[1] = 1'b0;
        step();
        step();

        // Randomized traffic against queue/shadow model
        do_reset();
        cyc = 0; rq.delete(); prev_v = 1'b0; n_acc0 = 0; n_acc1 = 0;
        prev_a = 11'h000; prev_d = 8'h00; prev_w = 1'b0;
        acc_prev[0] = 1'b0; acc_prev[1] = 1'b0;
        for (int n = 0; n < 800; n++) begin
            chk_b("rnd_excl", gnt0 & gnt1, 1'b0);
            chk_b("rnd_ce", vram_ce, prev_v);
            if (prev_v) begin
                chk_a("rnd_addr", vram_addr, prev_a);
                chk_d("rnd_din", vram_din, prev_d);
                chk_b("rnd_w", vram_w, prev_w);
            end
            ev0 = 1'b0; ev1 = 1'b0; ed = 8'h00;
            if (rq.size() != 0 && rq[0].due == cyc) begin
                e = rq.pop_front();
                if (e.port) ev1 = 1'b1; else ev0 = 1'b1;
                ed = e.data;
            end
            chk_b("rnd_rv0", rvalid0, ev0);
            chk_b("rnd_rv1", rvalid1, ev1);
            if (ev0 || ev1) chk_d("rnd_rdata", rdata, ed);

            for (int p = 0; p < 2; p++) begin
                if (n >= 790) begin
                    req[p] = 1'b0; lock[p] = 1'b0;
                end else begin
                    if (acc_prev[p] || !req[p]) begin
                        req[p]  = ($urandom_range(3) != 0);
                        addr[p] = 11'h400 | 11'($urandom_range(63));
                        w[p]    = 1'($urandom_range(1));
                        din[p]  = 8'($urandom);
                    end
                    lock[p] = ($urandom_range(15) == 0);
                end
            end
            acc[0] = req[0] & gnt0;
            acc[1] = req[1] & gnt1;
            prev_v = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    prev_v = 1'b1; prev_a = addr[p]; prev_d = din[p]; prev_w = w[p];
                    if (p == 0) n_acc0++; else n_acc1++;
                    if (w[p]) begin
                        shadow[addr[p]] = din[p];
                    end else begin
                        e.due = cyc + 3; e.port = 1'(p); e.data = shadow[addr[p]];
                        rq.push_back(e);
                    end
                end
            end
            acc_prev = acc;
            step();
        end
        chk_n("rnd_drain", rq.size(), 0);
        chk_b("rnd_progress", (n_acc0 > 40) && (n_acc1 > 40), 1'b1);

        // Asynchronous reset in the middle of a read burst
        do_reset();
        req[1] = 1'b1; w[1] = 1'b0; addr[1] = 11'h7C0;
        for (int c = 0; c < 5; c++) step();
        chk_b("ar_pre_rv1", rvalid1, 1'b1);
        #2;
        rst = 1'b1;
        req[1] = 1'b0;
        #1;
        chk_b("ar_gnt0", gnt0, 1'b0);
        chk_b("ar_gnt1", gnt1, 1'b0);
        chk_b("ar_ce", vram_ce, 1'b0);
        chk_b("ar_w", vram_w, 1'b0);
        chk_a("ar_addr", vram_addr, 11'h000);
        chk_d("ar_din", vram_din, 8'h00);
        chk_b("ar_rv0", rvalid0, 1'b0);
        chk_b("ar_rv1", rvalid1, 1'b0);
        chk_d("ar_rdata", rdata, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_b("ar_stray_rv1", rvalid1, 1'b0);
            chk_b("ar_stray_rv0", rvalid0, 1'b0);
        end
        req[1] = 1'b1;
        step();
        chk_b("ar_regrant", gnt1, 1'b1);
        req[1] = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
